// File: rtl/gol_pkg.sv
// gol_pkg: shared defaults and FSM state type for the Game of Life sweep core.
//   GOL_X_SIZE / GOL_Y_SIZE   : cells per row / rows per frame
//   GOL_X_WIDTH / GOL_Y_WIDTH : column index / row address widths
//   GOL_GEN_WIDTH             : generation counter width
//   gol_state_t               : sweep FSM states
package gol_pkg;

  localparam int GOL_X_SIZE    = 1280;
  localparam int GOL_Y_SIZE    = 720;
  localparam int GOL_X_WIDTH   = 11;
  localparam int GOL_Y_WIDTH   = 10;
  localparam int GOL_GEN_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } gol_state_t;

endpackage

// File: rtl/gol_row_rule.sv
// gol_row_rule: combinational next-state for one full row of cells.
//   i_top  : row above the row being updated
//   i_mid  : row being updated
//   i_bot  : row below
//   o_next : next state of i_mid
// Macro GOL_TORUS_EN: defined -> columns wrap (column -1 is X_SIZE-1,
// column X_SIZE is 0); undefined -> cells beyond the row ends read as dead.
module gol_row_rule
  import gol_pkg::*;
#(
  parameter int X_SIZE = GOL_X_SIZE
) (
  input  logic [X_SIZE-1:0] i_top,
  input  logic [X_SIZE-1:0] i_mid,
  input  logic [X_SIZE-1:0] i_bot,
  output logic [X_SIZE-1:0] o_next
);

  // Rows padded with one cell on each side: bit 0 is column -1,
  // bit c+1 is column c, bit X_SIZE+1 is column X_SIZE.
  logic [X_SIZE+1:0] w_top_x;
  logic [X_SIZE+1:0] w_mid_x;
  logic [X_SIZE+1:0] w_bot_x;

`ifdef GOL_TORUS_EN
  assign w_top_x = {i_top[0], i_top, i_top[X_SIZE-1]};
  assign w_mid_x = {i_mid[0], i_mid, i_mid[X_SIZE-1]};
  assign w_bot_x = {i_bot[0], i_bot, i_bot[X_SIZE-1]};
`else
  assign w_top_x = {1'b0, i_top, 1'b0};
  assign w_mid_x = {1'b0, i_mid, 1'b0};
  assign w_bot_x = {1'b0, i_bot, 1'b0};
`endif

  for (genvar c = 0; c < X_SIZE; c++) begin : g_col
    logic [3:0] w_cnt;
    assign w_cnt = 4'(w_top_x[c]) + 4'(w_top_x[c+1]) + 4'(w_top_x[c+2])
                 + 4'(w_mid_x[c])                     + 4'(w_mid_x[c+2])
                 + 4'(w_bot_x[c]) + 4'(w_bot_x[c+1]) + 4'(w_bot_x[c+2]);
    assign o_next[c] = (w_cnt == 4'd3) | (w_mid_x[c+1] & (w_cnt == 4'd2));
  end

endmodule

// File: rtl/gol_sweep_engine.sv
// gol_sweep_engine: per-generation row sweep. Reads rows through the line
// buffer fetch port into a 3-row window, applies the rule to a whole row per
// cycle and emits each next-state row on the parallel write port.
//   clk, rst                         : clock, synchronous active-high reset
//   mode                             : pause; 1 blocks acceptance of start
//   start                            : request one sweep (pulse or level)
//   busy                             : sweep in progress
//   done                             : one-cycle pulse after last row write
//   line_buffer_fetch_addr           : row address into current-state BRAM
//   line_buffer_fetch_mem            : row data, 1 cycle after its address
//   parallel_next_state_result       : next-state row
//   parallel_next_state_write_addr   : row index of the result
//   parallel_next_state_write_en     : one strobe per row
//   generation_count                 : completed generations (wrapping)
// Macro GOL_TORUS_EN: defined -> full torus; undefined -> bounded plane
// (the wrapped first/last captures load zero, row ends read as dead).
module gol_sweep_engine
  import gol_pkg::*;
#(
  parameter int X_SIZE    = GOL_X_SIZE,
  parameter int Y_SIZE    = GOL_Y_SIZE,
  parameter int X_WIDTH   = GOL_X_WIDTH,
  parameter int Y_WIDTH   = GOL_Y_WIDTH,
  parameter int GEN_WIDTH = GOL_GEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [Y_WIDTH-1:0]   line_buffer_fetch_addr,
  input  logic [X_SIZE-1:0]    line_buffer_fetch_mem,
  output logic [X_SIZE-1:0]    parallel_next_state_result,
  output logic [Y_WIDTH-1:0]   parallel_next_state_write_addr,
  output logic                 parallel_next_state_write_en,
  output logic [GEN_WIDTH-1:0] generation_count
);

  if ((1 << X_WIDTH) < X_SIZE) begin : g_bad_x_width
    $error("X_WIDTH too narrow for X_SIZE");
  end

  // Fetch index k runs 0..Y_SIZE+1; k=0 is the acceptance cycle itself.
  localparam int                 KW       = $clog2(Y_SIZE + 2);
  localparam logic [KW-1:0]      K_LAST   = KW'(Y_SIZE + 1);
  localparam logic [KW-1:0]      K_FIRST  = KW'(2);
  localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);

  gol_state_t         r_state;
  logic [KW-1:0]      r_fk;
  logic [Y_WIDTH-1:0] r_addr;
  logic [Y_WIDTH-1:0] r_row;
  logic [X_SIZE-1:0]  r_top;
  logic [X_SIZE-1:0]  r_mid;
  logic [X_SIZE-1:0]  r_bot;
  logic               r_cap_vld;
  // [0]: row's bottom neighbour on the bus, [1]: window holds the row
  logic [1:0]         r_vld_pipe;

  logic               w_accept;
  logic               w_fetch;
  logic               w_row_issue;
  logic [X_SIZE-1:0]  w_cap;
  logic [X_SIZE-1:0]  w_next;

  assign w_fetch  = (r_state == FETCH);
  assign w_accept = ~rst & (r_state == IDLE) & start & ~mode;
  // Fetch k>=2 brings in the bottom neighbour of row k-2.
  assign w_row_issue = w_fetch & (r_fk >= K_FIRST);

  // Fetch 0 (row Y_SIZE-1) must reach the BRAM in the acceptance cycle,
  // so that one address bypasses the register.
  assign line_buffer_fetch_addr = w_accept ? ROW_LAST : r_addr;

`ifdef GOL_TORUS_EN
  assign w_cap = line_buffer_fetch_mem;
`else
  // Set for the captures of fetch 0 and fetch Y_SIZE+1 (the wrapped rows).
  logic r_cap_zero;
  assign w_cap = r_cap_zero ? '0 : line_buffer_fetch_mem;
`endif

  gol_row_rule #(
    .X_SIZE (X_SIZE)
  ) u_rule (
    .i_top  (r_top),
    .i_mid  (r_mid),
    .i_bot  (r_bot),
    .o_next (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                        <= IDLE;
      r_fk                           <= '0;
      r_addr                         <= '0;
      r_row                          <= '0;
      r_top                          <= '0;
      r_mid                          <= '0;
      r_bot                          <= '0;
      r_cap_vld                      <= 1'b0;
      r_vld_pipe                     <= '0;
`ifndef GOL_TORUS_EN
      r_cap_zero                     <= 1'b0;
`endif
      busy                           <= 1'b0;
      done                           <= 1'b0;
      parallel_next_state_result     <= '0;
      parallel_next_state_write_addr <= '0;
      parallel_next_state_write_en   <= 1'b0;
      generation_count               <= '0;
    end else begin
      // Window capture: data for an address is on the bus the next cycle.
      r_cap_vld <= w_accept | w_fetch;
`ifndef GOL_TORUS_EN
      r_cap_zero <= w_accept | (w_fetch & (r_fk == K_LAST));
`endif
      if (r_cap_vld) begin
        r_top <= r_mid;
        r_mid <= r_bot;
        r_bot <= w_cap;
      end

      r_vld_pipe                   <= {r_vld_pipe[0], w_row_issue};
      parallel_next_state_write_en <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        parallel_next_state_result     <= w_next;
        parallel_next_state_write_addr <= r_row;
        r_row                          <= r_row + 1'b1;
      end

      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= FETCH;
            busy    <= 1'b1;
            r_fk    <= KW'(1);
            r_addr  <= '0;
            r_row   <= '0;
          end
        end
        FETCH: begin
          if (r_fk == K_LAST) begin
            r_state <= DRAIN;
          end else begin
            r_fk   <= r_fk + 1'b1;
            r_addr <= (r_addr == ROW_LAST) ? '0 : r_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Last row's write strobe is out this cycle.
          if (parallel_next_state_write_en &&
              (parallel_next_state_write_addr == ROW_LAST)) begin
            r_state          <= DONE;
            done             <= 1'b1;
            generation_count <= generation_count + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_sweep_engine.sv
// tb_gol_sweep_engine: directed bench for gol_sweep_engine with X_SIZE=8,
// Y_SIZE=6 and a 1-cycle-latency row memory. Cycle 0 of each run is the
// cycle start is first presented.
module tb_gol_sweep_engine;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        start;
  logic        busy;
  logic        done;
  logic [2:0]  fetch_addr;
  logic [7:0]  fetch_mem;
  logic [7:0]  result;
  logic [2:0]  write_addr;
  logic        write_en;
  logic [15:0] gen;

  logic [7:0]  mem [0:5];

  int          n_chk;
  int          n_err;

  // per-run records
  logic [2:0]  fa [64];
  logic        bz [64];
  logic [7:0]  wr_row [6];
  int          wr_at [6];
  int          wr_cnt;
  int          done_cnt;
  int          done_at [4];
  logic [15:0] done_gen [4];
  int          busy_cnt;
  logic [15:0] gen_last;

  int          exp_fa [8] = '{5, 0, 1, 2, 3, 4, 5, 0};

  gol_sweep_engine #(
    .X_SIZE    (8),
    .Y_SIZE    (6),
    .X_WIDTH   (3),
    .Y_WIDTH   (3),
    .GEN_WIDTH (16)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .mode                           (mode),
    .start                          (start),
    .busy                           (busy),
    .done                           (done),
    .line_buffer_fetch_addr         (fetch_addr),
    .line_buffer_fetch_mem          (fetch_mem),
    .parallel_next_state_result     (result),
    .parallel_next_state_write_addr (write_addr),
    .parallel_next_state_write_en   (write_en),
    .generation_count               (gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) fetch_mem <= mem[fetch_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive start from smask, pulse rst in cycle rst_at, sample n cycles.
  task automatic run(input logic [63:0] smask, input int rst_at, input int n);
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int r = 0; r < 6; r++) begin wr_row[r] = '0; wr_at[r] = -1; end
    for (int c = 0; c < n; c++) begin
      start = smask[c];
      rst   = (c == rst_at);
      @(negedge clk);
      fa[c] = fetch_addr;
      bz[c] = busy;
      if (busy) busy_cnt++;
      if (write_en) begin
        wr_cnt++;
        if (write_addr < 3'd6) begin
          wr_row[write_addr] = result;
          wr_at[write_addr]  = c;
        end
      end
      if (done) begin
        if (done_cnt < 4) begin done_at[done_cnt] = c; done_gen[done_cnt] = gen; end
        done_cnt++;
      end
      gen_last = gen;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  // Expected rows packed {r5,r4,r3,r2,r1,r0}; also checks write cycle r+5.
  task automatic chk_rows(input string tag, input logic [47:0] e);
    chk({tag, "_wcnt"}, wr_cnt, 6);
    for (int r = 0; r < 6; r++) begin
      chk($sformatf("%s_row%0d", tag, r), wr_row[r], e[r*8 +: 8]);
      chk($sformatf("%s_at%0d", tag, r), wr_at[r], r + 5);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    mem = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", write_en, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_res", result, 0);
    chk("rst_gen", gen, 0);
    chk("rst_faddr", fetch_addr, 0);
    @(posedge clk); #1;

    // vertical blinker, column 3, rows 1-3
    mem = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
    run(64'h1, -1, 13);
    chk_rows("blk", 48'h00_00_00_1C_00_00);
    chk("blk_dcnt", done_cnt, 1);
    chk("blk_dat", done_at[0], 11);
    chk("blk_gen", done_gen[0], 1);
    chk("blk_busy", busy_cnt, 11);
    chk("blk_busy0", bz[0], 0);
    for (int k = 0; k < 8; k++) chk($sformatf("blk_fa%0d", k), fa[k], exp_fa[k]);
    chk("blk_fa_hold", fa[12], 0);

    // second generation returns to vertical
    for (int r = 0; r < 6; r++) mem[r] = wr_row[r];
    run(64'h1, -1, 13);
    chk_rows("blk2", 48'h00_00_08_08_08_00);
    chk("blk2_gen", done_gen[0], 2);

    // paused: start ignored
    mode = 1'b1;
    run(64'h1, -1, 8);
    chk("pause_busy", busy_cnt, 0);
    chk("pause_wcnt", wr_cnt, 0);
    chk("pause_dcnt", done_cnt, 0);
    chk("pause_fa0", fa[0], 0);
    chk("pause_gen", gen_last, 2);
    mode = 1'b0;
    run(64'h1, -1, 13);
    chk("unpause_wcnt", wr_cnt, 6);
    chk("unpause_gen", done_gen[0], 3);
    chk("unpause_fa0", fa[0], 5);

    // start re-pulsed in cycle 3 of a sweep
    run(64'h9, -1, 16);
    chk("restart_wcnt", wr_cnt, 6);
    chk("restart_dcnt", done_cnt, 1);
    chk("restart_dat", done_at[0], 11);
    chk("restart_gen", done_gen[0], 4);

    // glider crossing the bottom-right corner
    mem = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h80, 8'hE0};
    run(64'h1, -1, 13);
`ifdef GOL_TORUS_EN
    chk_rows("glider", 48'hC0_A0_00_00_00_40);
`else
    chk_rows("glider", 48'hC0_A0_00_00_00_00);
`endif

    // horizontal blinker across the column seam (columns 7,0,1)
    mem = '{8'h00, 8'h00, 8'h83, 8'h00, 8'h00, 8'h00};
    run(64'h1, -1, 13);
`ifdef GOL_TORUS_EN
    chk_rows("seam", 48'h00_00_01_01_01_00);
`else
    chk_rows("seam", 48'h00_00_00_00_00_00);
`endif

    // reset in cycle 7 of a sweep
    run(64'h1, 7, 14);
    chk("rmid_wcnt", wr_cnt, 3);
    chk("rmid_at3", wr_at[3], -1);
    chk("rmid_dcnt", done_cnt, 0);
    chk("rmid_busy7", bz[7], 1);
    chk("rmid_busy8", bz[8], 0);
    chk("rmid_gen", gen_last, 0);
    run(64'h1, -1, 13);
    chk("rfresh_wcnt", wr_cnt, 6);
    chk("rfresh_dcnt", done_cnt, 1);
    chk("rfresh_gen", done_gen[0], 1);

    // start held: back-to-back sweeps from a cleared counter
    run(64'h0, 0, 2);
    run(64'hF_FFFF_FFFF, -1, 36);
    chk("b2b_wcnt", wr_cnt, 18);
    chk("b2b_dcnt", done_cnt, 3);
    chk("b2b_busy", busy_cnt, 33);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("b2b_dat%0d", j), done_at[j], 11 + 12 * j);
      chk($sformatf("b2b_gen%0d", j), done_gen[j], j + 1);
      for (int k = 0; k < 8; k++)
        chk($sformatf("b2b_fa%0d_%0d", j, k), fa[12 * j + k], exp_fa[k]);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
